// File: rtl/mlx_frame_parser.sv
// Frame parser for the GY-MCU90640 UART stream: finds 5A 5A headers, writes the 768 pixel words
// to the pixel RAM port, verifies the 16-bit checksum and reports each frame as done or errored.
module mlx_frame_parser #(
    parameter int         NUM_PIX     = 768,
    parameter logic [7:0] LEN_LO      = 8'h02,
    parameter logic [7:0] LEN_HI      = 8'h06,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        uart_done,
    input  logic [7:0]  uart_data,
    output logic        pix_we,
    output logic [9:0]  pix_addr,
    output logic [15:0] pix_data,
    output logic [15:0] ta_data,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [15:0]      HDR_WORD = 16'h5A5A;
    localparam logic [15:0]      LEN_WORD = {LEN_HI, LEN_LO};
    localparam logic [9:0]       LAST_PIX = 10'(NUM_PIX - 1);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        HUNT0, HUNT1, LEN0, LEN1, PIX_LO, PIX_HI, TA_LO, TA_HI, CK_LO, CK_HI
    } state_t;

    state_t           state, state_n;
    logic             uart_done_d;
    logic [7:0]       lo_byte, lo_byte_n;
    logic [9:0]       pix_cnt, pix_cnt_n;
    logic [15:0]      cksum, cksum_n;
    logic [15:0]      ta_shadow, ta_shadow_n;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_n;
    logic             pix_we_n, frame_done_n, frame_err_n, busy_n;
    logic [9:0]       pix_addr_n;
    logic [15:0]      pix_data_n, ta_data_n;
    logic             accept, in_frame, timeout;
    logic [15:0]      rx_word;

    always_comb begin
        accept       = uart_done && !uart_done_d;
        rx_word      = {uart_data, lo_byte};
        in_frame     = (state != HUNT0) && (state != HUNT1);
        timeout      = in_frame && !accept && (idle_cnt == IDLE_MAX);

        state_n      = state;
        lo_byte_n    = lo_byte;
        pix_cnt_n    = pix_cnt;
        cksum_n      = cksum;
        ta_shadow_n  = ta_shadow;
        ta_data_n    = ta_data;
        pix_addr_n   = pix_addr;
        pix_data_n   = pix_data;
        pix_we_n     = 1'b0;
        frame_done_n = 1'b0;
        frame_err_n  = 1'b0;
        idle_cnt_n   = (accept || !in_frame) ? '0 : idle_cnt + 1'b1;

        // An accept in the same cycle as the timeout wins, so timeout already excludes accept.
        if (timeout) begin
            state_n     = HUNT0;
            frame_err_n = 1'b1;
            idle_cnt_n  = '0;
        end else if (accept) begin
            case (state)
                HUNT0: if (uart_data == 8'h5A) state_n = HUNT1;
                HUNT1: begin
                    if (uart_data == 8'h5A) begin
                        state_n = LEN0;
                        cksum_n = HDR_WORD;
                    end else begin
                        state_n = HUNT0;
                    end
                end
                LEN0: state_n = (uart_data == LEN_LO) ? LEN1 : HUNT0;
                LEN1: begin
                    if (uart_data == LEN_HI) begin
                        state_n   = PIX_LO;
                        pix_cnt_n = '0;
                        cksum_n   = cksum + LEN_WORD;
                    end else begin
                        state_n = HUNT0;
                    end
                end
                PIX_LO: begin
                    lo_byte_n = uart_data;
                    state_n   = PIX_HI;
                end
                PIX_HI: begin
                    pix_we_n   = 1'b1;
                    pix_addr_n = pix_cnt;
                    pix_data_n = rx_word;
                    cksum_n    = cksum + rx_word;
                    pix_cnt_n  = pix_cnt + 10'd1;
                    state_n    = (pix_cnt == LAST_PIX) ? TA_LO : PIX_LO;
                end
                TA_LO: begin
                    lo_byte_n = uart_data;
                    state_n   = TA_HI;
                end
                TA_HI: begin
                    ta_shadow_n = rx_word;
                    cksum_n     = cksum + rx_word;
                    state_n     = CK_LO;
                end
                CK_LO: begin
                    lo_byte_n = uart_data;
                    state_n   = CK_HI;
                end
                CK_HI: begin
                    if (rx_word == cksum) begin
                        ta_data_n    = ta_shadow;
                        frame_done_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                    state_n = HUNT0;
                end
                default: state_n = HUNT0;
            endcase
        end

        busy_n = (state_n != HUNT0) && (state_n != HUNT1);
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state       <= HUNT0;
            uart_done_d <= 1'b0;
            lo_byte     <= '0;
            pix_cnt     <= '0;
            cksum       <= '0;
            ta_shadow   <= '0;
            idle_cnt    <= '0;
            pix_we      <= 1'b0;
            pix_addr    <= '0;
            pix_data    <= '0;
            ta_data     <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            uart_done_d <= uart_done;
            lo_byte     <= lo_byte_n;
            pix_cnt     <= pix_cnt_n;
            cksum       <= cksum_n;
            ta_shadow   <= ta_shadow_n;
            idle_cnt    <= idle_cnt_n;
            pix_we      <= pix_we_n;
            pix_addr    <= pix_addr_n;
            pix_data    <= pix_data_n;
            ta_data     <= ta_data_n;
            frame_done  <= frame_done_n;
            frame_err   <= frame_err_n;
            busy        <= busy_n;
        end
    end
endmodule

// File: tb/tb_mlx_frame_parser.sv
// Directed/randomised bench for mlx_frame_parser: frames are built from a pixel table and the
// expected checksum, writes and pulses are derived from that table with plain arithmetic.
module tb_mlx_frame_parser;
    localparam int NUM_PIX = 768;

    logic        clk_50m = 1'b0;
    logic        rst;
    logic        uart_done;
    logic [7:0]  uart_data;
    logic        pix_we;
    logic [9:0]  pix_addr;
    logic [15:0] pix_data;
    logic [15:0] ta_data;
    logic        frame_done;
    logic        frame_err;
    logic        busy;

    always #10 clk_50m = ~clk_50m;

    mlx_frame_parser dut (
        .clk_50m    (clk_50m),
        .rst        (rst),
        .uart_done  (uart_done),
        .uart_data  (uart_data),
        .pix_we     (pix_we),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .ta_data    (ta_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    logic [15:0] pix_mem [1024];
    int n_checks = 0;
    int n_pass   = 0;

    // Event monitor: counts writes/pulses and flags writes that disagree with the pixel table.
    int   n_wr = 0, n_wr_bad = 0, n_done = 0, n_err = 0, n_overlap = 0, n_long = 0;
    logic prev_we = 1'b0, prev_done = 1'b0, prev_err = 1'b0;

    always @(negedge clk_50m) begin
        if (pix_we) begin
            n_wr <= n_wr + 1;
            if (pix_data !== pix_mem[pix_addr]) n_wr_bad <= n_wr_bad + 1;
        end
        if (frame_done) n_done <= n_done + 1;
        if (frame_err)  n_err  <= n_err + 1;
        if (int'(pix_we) + int'(frame_done) + int'(frame_err) > 1) n_overlap <= n_overlap + 1;
        if ((pix_we && prev_we) || (frame_done && prev_done) || (frame_err && prev_err))
            n_long <= n_long + 1;
        prev_we   <= pix_we;
        prev_done <= frame_done;
        prev_err  <= frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk_50m);
        uart_data = b;
        uart_done = 1'b1;
        repeat (hold) @(negedge clk_50m);
        uart_done = 1'b0;
    endtask

    task automatic send_rnd(input logic [7:0] b);
        send_byte(b, int'($urandom_range(2, 1)));
    endtask

    task automatic send_header(input int hold);
        send_byte(8'h5A, hold);
        send_byte(8'h5A, hold);
        send_byte(8'h02, hold);
        send_byte(8'h06, hold);
    endtask

    function automatic logic [15:0] frame_sum(input logic [15:0] ta);
        logic [15:0] s = 16'h5A5A + 16'h0602 + ta;
        for (int k = 0; k < NUM_PIX; k++) s = s + pix_mem[k];
        return s;
    endfunction

    task automatic send_frame(input logic [15:0] ta, input logic [15:0] ck_delta, input int hdr_hold);
        logic [15:0] ck = frame_sum(ta) + ck_delta;
        send_header(hdr_hold);
        for (int k = 0; k < NUM_PIX; k++) begin
            send_rnd(pix_mem[k][7:0]);
            send_rnd(pix_mem[k][15:8]);
        end
        send_rnd(ta[7:0]);
        send_rnd(ta[15:8]);
        send_rnd(ck[7:0]);
        send_rnd(ck[15:8]);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk_50m);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_we"},   32'(pix_we),     32'd0);
        check({pfx, "_addr"}, 32'(pix_addr),   32'd0);
        check({pfx, "_data"}, 32'(pix_data),   32'd0);
        check({pfx, "_ta"},   32'(ta_data),    32'd0);
        check({pfx, "_done"}, 32'(frame_done), 32'd0);
        check({pfx, "_err"},  32'(frame_err),  32'd0);
        check({pfx, "_busy"}, 32'(busy),       32'd0);
    endtask

    initial begin
        int w0, b0, d0, e0;
        logic [15:0] ta_r, ck;
        logic [7:0] garbage [6];

        rst = 1'b1;
        uart_done = 1'b0;
        uart_data = 8'h00;
        for (int k = 0; k < 1024; k++) pix_mem[k] = 16'h0;
        repeat (3) @(negedge clk_50m);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Good frame with slow header bytes.
        for (int k = 0; k < NUM_PIX; k++) pix_mem[k] = 16'h0100 + 16'(k);
        w0 = n_wr; b0 = n_wr_bad; d0 = n_done; e0 = n_err;
        send_frame(16'h0C80, 16'h0, 200);
        settle();
        check("good_writes", 32'(n_wr - w0), 32'd768);
        check("good_bad",    32'(n_wr_bad - b0), 32'd0);
        check("good_done",   32'(n_done - d0), 32'd1);
        check("good_err",    32'(n_err - e0), 32'd0);
        check("good_ta",     32'(ta_data), 32'h0C80);
        check("good_busy",   32'(busy), 32'd0);

        // Bad checksum, random pixels.
        for (int k = 0; k < NUM_PIX; k++) pix_mem[k] = 16'($urandom);
        w0 = n_wr; b0 = n_wr_bad; d0 = n_done; e0 = n_err;
        send_frame(16'($urandom), 16'h1, 1);
        settle();
        check("badck_writes", 32'(n_wr - w0), 32'd768);
        check("badck_bad",    32'(n_wr_bad - b0), 32'd0);
        check("badck_done",   32'(n_done - d0), 32'd0);
        check("badck_err",    32'(n_err - e0), 32'd1);
        check("badck_ta",     32'(ta_data), 32'h0C80);

        // Garbage and false headers, then a good random frame.
        garbage = '{8'h00, 8'h5A, 8'h13, 8'h5A, 8'h5A, 8'h07};
        w0 = n_wr; d0 = n_done; e0 = n_err;
        for (int i = 0; i < 6; i++) send_rnd(garbage[i]);
        settle();
        check("garb_writes", 32'(n_wr - w0), 32'd0);
        check("garb_done",   32'(n_done - d0), 32'd0);
        check("garb_err",    32'(n_err - e0), 32'd0);
        check("garb_busy",   32'(busy), 32'd0);
        for (int k = 0; k < NUM_PIX; k++) pix_mem[k] = 16'($urandom);
        ta_r = 16'($urandom);
        w0 = n_wr; b0 = n_wr_bad; d0 = n_done; e0 = n_err;
        send_frame(ta_r, 16'h0, 1);
        settle();
        check("resync_writes", 32'(n_wr - w0), 32'd768);
        check("resync_bad",    32'(n_wr_bad - b0), 32'd0);
        check("resync_done",   32'(n_done - d0), 32'd1);
        check("resync_err",    32'(n_err - e0), 32'd0);
        check("resync_ta",     32'(ta_data), 32'(ta_r));

        // Timeout after 50 pixels.
        for (int k = 0; k < NUM_PIX; k++) pix_mem[k] = 16'($urandom);
        w0 = n_wr; b0 = n_wr_bad; d0 = n_done; e0 = n_err;
        send_header(1);
        for (int k = 0; k < 50; k++) begin
            send_rnd(pix_mem[k][7:0]);
            send_rnd(pix_mem[k][15:8]);
        end
        settle();
        check("tmo_busy_pre", 32'(busy), 32'd1);
        repeat (49800) @(negedge clk_50m);
        check("tmo_early_err", 32'(n_err - e0), 32'd0);
        check("tmo_early_busy", 32'(busy), 32'd1);
        repeat (400) @(negedge clk_50m);
        check("tmo_writes", 32'(n_wr - w0), 32'd50);
        check("tmo_bad",    32'(n_wr_bad - b0), 32'd0);
        check("tmo_err",    32'(n_err - e0), 32'd1);
        check("tmo_done",   32'(n_done - d0), 32'd0);
        check("tmo_busy",   32'(busy), 32'd0);
        check("tmo_ta",     32'(ta_data), 32'(ta_r));
        d0 = n_done; e0 = n_err;
        send_frame(16'h1234, 16'h0, 1);
        settle();
        check("post_tmo_done", 32'(n_done - d0), 32'd1);
        check("post_tmo_err",  32'(n_err - e0), 32'd0);
        check("post_tmo_ta",   32'(ta_data), 32'h1234);

        // Reset after pixel 300; remaining bytes must be ignored.
        for (int k = 0; k < NUM_PIX; k++) pix_mem[k] = 16'h0100 + 16'(k);
        w0 = n_wr;
        send_header(1);
        for (int k = 0; k < 300; k++) begin
            send_rnd(pix_mem[k][7:0]);
            send_rnd(pix_mem[k][15:8]);
        end
        settle();
        check("rstmid_writes", 32'(n_wr - w0), 32'd300);
        @(negedge clk_50m);
        rst = 1'b1;
        @(negedge clk_50m);
        rst = 1'b0;
        check_outputs_zero("rstmid");
        w0 = n_wr; d0 = n_done; e0 = n_err;
        for (int k = 300; k < NUM_PIX; k++) begin
            send_rnd(pix_mem[k][7:0]);
            send_rnd(pix_mem[k][15:8]);
        end
        ck = frame_sum(16'h0C80);
        send_rnd(8'h80);
        send_rnd(8'h0C);
        send_rnd(ck[7:0]);
        send_rnd(ck[15:8]);
        settle();
        check("rstmid_tail_writes", 32'(n_wr - w0), 32'd0);
        check("rstmid_tail_done",   32'(n_done - d0), 32'd0);
        check("rstmid_tail_err",    32'(n_err - e0), 32'd0);
        check("rstmid_tail_busy",   32'(busy), 32'd0);

        // Checksum wrap with all-ones payload.
        for (int k = 0; k < NUM_PIX; k++) pix_mem[k] = 16'hFFFF;
        w0 = n_wr; b0 = n_wr_bad; d0 = n_done; e0 = n_err;
        send_frame(16'hFFFF, 16'h0, 1);
        settle();
        check("wrap_writes", 32'(n_wr - w0), 32'd768);
        check("wrap_bad",    32'(n_wr_bad - b0), 32'd0);
        check("wrap_done",   32'(n_done - d0), 32'd1);
        check("wrap_err",    32'(n_err - e0), 32'd0);
        check("wrap_ta",     32'(ta_data), 32'hFFFF);

        check("pulse_overlap", 32'(n_overlap), 32'd0);
        check("pulse_width",   32'(n_long), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
